traffic_light_fsm: RTL and testbench
====================================

Name: traffic_light_fsm

Overview:
- Sequencing controller for a main-road/side-road intersection with a pedestrian crossing.
- Sits directly upstream of the LED decode stage and drives its 7-bit LED vector: bit6 Rm, bit5 Ym, bit4 Gm, bit3 Rs, bit2 Ys, bit1 Gs, bit0 Walk.
- Times each phase with a prescaled tick counter.
- Serves side-road traffic and pedestrian requests on demand; the main road rests in green.

Parameters:
- TICK_DIV, 50000000: clock cycles per timing tick (1 s at 50 MHz); the bench uses 4.
- T_MAIN_MIN, 10: minimum main-green duration, in ticks.
- T_YELLOW, 3: yellow duration for either road, in ticks.
- T_ALL_RED, 1: all-red clearance duration, in ticks.
- T_SIDE_GREEN, 5: side-green duration, in ticks.
- T_WALK, 4: walk phase duration, in ticks.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- side_sensor  in  1  level; high while a vehicle waits on the side road.
- walk_req  in  1  pedestrian button; a one-cycle pulse or a level.
- leds  out  7  {Rm,Ym,Gm,Rs,Ys,Gs,Walk}; feeds the LED decode stage.
- walk_pending  out  1  a pedestrian request is latched and not yet served.

Behaviour:
- All outputs are registered.
- Reset state is MAIN_GREEN, leds=7'b0011000, walk_pending=0, timers cleared.
- rst has priority over every other event, including mid-phase; the next cycle after a reset is cycle 0 of MAIN_GREEN.
- States and leds encodings:
  - MAIN_GREEN 0011000
  - MAIN_YELLOW 0101000
  - ALL_RED_A 1001000
  - SIDE_GREEN 1000010
  - SIDE_YELLOW 1000100
  - WALK 1001001
  - ALL_RED_B 1001000
- Timing:
  - The prescaler counts 0..TICK_DIV-1 and emits a tick when the count equals TICK_DIV-1.
  - The phase counter counts ticks within the current state.
  - Both counters clear on every state change, so a phase of T ticks lasts exactly T*TICK_DIV clock cycles.
- "Phase done" means: a tick occurs and the phase count equals T-1.
- Transitions:
  - MAIN_GREEN -> MAIN_YELLOW on the first cycle where min_done && (side_sensor || walk_pending). min_done is a sticky flag set at the T_MAIN_MIN-th tick. Until that condition holds, MAIN_GREEN holds indefinitely.
  - MAIN_YELLOW -> ALL_RED_A when its phase is done.
  - ALL_RED_A -> WALK if walk_pending=1, else -> SIDE_GREEN. Walk has priority over the side road.
  - SIDE_GREEN -> SIDE_YELLOW when its phase is done. The side green runs the full T_SIDE_GREEN even if side_sensor drops.
  - SIDE_YELLOW -> ALL_RED_B when its phase is done.
  - WALK -> ALL_RED_B when its phase is done.
  - ALL_RED_B -> MAIN_GREEN when its phase is done. min_done clears on entry to MAIN_GREEN.
- leds updates on the same edge as the state register. No intermediate or glitch value ever appears.
- Invariant: exactly one of Rm/Ym/Gm is set and exactly one of Rs/Ys/Gs is set. Walk=1 only in WALK, and only with Rm and Rs both set.
- walk_pending:
  - Set on any cycle where walk_req=1 while the state is not WALK.
  - Cleared on the edge that enters WALK.
  - walk_req in the same cycle as entry to WALK is absorbed and not re-latched.
  - walk_req during WALK is ignored.
- A side request waiting while WALK is served gets its green on the next main cycle, after T_MAIN_MIN.
- The side sensor is not latched: if it drops before min_done, no side phase runs.
- Counter widths are $clog2 of each maximum, minimum 1 bit.
- No arithmetic overflow is possible, because all counters clear at their terminal value.

Decomposition:
- traffic_pkg holds:
  - the state enum (3-bit);
  - the seven LED encoding constants;
  - localparams naming each LED bit index.
- One sub-module, phase_timer:
  - contains the prescaler and phase counter;
  - inputs: clk, rst, clear, and terminal count;
  - outputs: tick and done.
- The FSM instantiates phase_timer once and muxes the terminal count by state.

Test Plan:
All scenarios use TICK_DIV=4 with the default T values.
- Reset: assert rst for 2 cycles mid-SIDE_GREEN -> the next cycle shows leds=0011000 and walk_pending=0; MAIN_GREEN restarts its timing from zero.
- Idle: no requests for 200 cycles -> leds stays 0011000 and the state never leaves MAIN_GREEN.
- Side cycle: side_sensor=1 from cycle 5 -> MAIN_YELLOW at cycle 40, ALL_RED_A at 52, SIDE_GREEN at 56, SIDE_YELLOW at 76, ALL_RED_B at 88, MAIN_GREEN at 92.
- Walk priority: a walk_req pulse at cycle 3 plus side_sensor=1 -> walk_pending=1 from cycle 4; WALK (1001001) at cycle 56; walk_pending=0 at 56; ALL_RED_B at 72; MAIN_GREEN at 76; then the side phase follows after a further 40 cycles.
- Request edge cases: walk_req during WALK -> walk_pending stays 0. walk_req on the exact ALL_RED_A->WALK edge -> not re-latched. side_sensor pulsed only in cycles 0-10 -> no side phase.
- Invariant checker, running in all scenarios: exactly one of leds[6:4] is set, exactly one of leds[3:1] is set, and leds[0] implies leds[6] && leds[3].

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller: state enum, LED
// encodings and LED bit positions.
package traffic_pkg;

  typedef enum logic [2:0] {
    StMainGreen  = 3'd0,
    StMainYellow = 3'd1,
    StAllRedA    = 3'd2,
    StSideGreen  = 3'd3,
    StSideYellow = 3'd4,
    StWalk       = 3'd5,
    StAllRedB    = 3'd6
  } state_e;

  localparam int unsigned LedRm   = 6;
  localparam int unsigned LedYm   = 5;
  localparam int unsigned LedGm   = 4;
  localparam int unsigned LedRs   = 3;
  localparam int unsigned LedYs   = 2;
  localparam int unsigned LedGs   = 1;
  localparam int unsigned LedWalk = 0;

  localparam logic [6:0] LedsMainGreen  = 7'b0011000;
  localparam logic [6:0] LedsMainYellow = 7'b0101000;
  localparam logic [6:0] LedsAllRedA    = 7'b1001000;
  localparam logic [6:0] LedsSideGreen  = 7'b1000010;
  localparam logic [6:0] LedsSideYellow = 7'b1000100;
  localparam logic [6:0] LedsWalk       = 7'b1001001;
  localparam logic [6:0] LedsAllRedB    = 7'b1001000;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] state_leds(state_e s);
    logic [6:0] l;
    l = LedsAllRedA;
    unique case (s)
      StMainGreen:  l = LedsMainGreen;
      StMainYellow: l = LedsMainYellow;
      StAllRedA:    l = LedsAllRedA;
      StSideGreen:  l = LedsSideGreen;
      StSideYellow: l = LedsSideYellow;
      StWalk:       l = LedsWalk;
      StAllRedB:    l = LedsAllRedB;
      default:      l = LedsAllRedA;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Prescaled phase timer: a tick every TICK_DIV cycles and a done strobe on the
// tick where the phase count reaches the terminal value.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned PH_W     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [PH_W-1:0] term,
  output logic            tick,
  output logic            done
);

  localparam int unsigned PS_W = cnt_width(TICK_DIV);
  localparam logic [PS_W-1:0] PsLast = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic [PH_W-1:0] ph_q, ph_d;

  assign tick = (ps_q == PsLast);
  assign done = tick && (ph_q == term);

  always_comb begin
    ps_d = tick ? '0 : ps_q + PS_W'(1);
    ph_d = ph_q;
    if (tick) begin
      ph_d = (ph_q == term) ? '0 : ph_q + PH_W'(1);
    end
    // A state change restarts timing from the top of the new phase.
    if (clear) begin
      ps_d = '0;
      ph_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q <= '0;
      ph_q <= '0;
    end else begin
      ps_q <= ps_d;
      ph_q <= ph_d;
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side road intersection controller with pedestrian walk phase; main road
// rests in green and other phases are served on demand.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned T_MAIN_MIN   = 10,
  parameter int unsigned T_YELLOW     = 3,
  parameter int unsigned T_ALL_RED    = 1,
  parameter int unsigned T_SIDE_GREEN = 5,
  parameter int unsigned T_WALK       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_sensor,
  input  logic       walk_req,
  output logic [6:0] leds,
  output logic       walk_pending
);

  localparam int unsigned TMax01 = (T_MAIN_MIN > T_YELLOW) ? T_MAIN_MIN : T_YELLOW;
  localparam int unsigned TMax23 = (T_ALL_RED > T_SIDE_GREEN) ? T_ALL_RED : T_SIDE_GREEN;
  localparam int unsigned TMax03 = (TMax01 > TMax23) ? TMax01 : TMax23;
  localparam int unsigned TMax   = (TMax03 > T_WALK) ? TMax03 : T_WALK;
  localparam int unsigned PH_W   = cnt_width(TMax);

  localparam logic [PH_W-1:0] TermMain   = PH_W'(T_MAIN_MIN - 1);
  localparam logic [PH_W-1:0] TermYellow = PH_W'(T_YELLOW - 1);
  localparam logic [PH_W-1:0] TermAllRed = PH_W'(T_ALL_RED - 1);
  localparam logic [PH_W-1:0] TermSide   = PH_W'(T_SIDE_GREEN - 1);
  localparam logic [PH_W-1:0] TermWalk   = PH_W'(T_WALK - 1);

  state_e          state_q, state_d;
  logic [6:0]      leds_q, leds_d;
  logic            pend_q, pend_d;
  logic            min_done_q, min_done_d;
  logic [PH_W-1:0] term;
  logic            clear;
  logic            done;
  logic            timer_tick_unused;

  phase_timer #(
    .TICK_DIV (TICK_DIV),
    .PH_W     (PH_W)
  ) u_phase_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .term  (term),
    .tick  (timer_tick_unused),
    .done  (done)
  );

  always_comb begin
    term = TermMain;
    unique case (state_q)
      StMainGreen:               term = TermMain;
      StMainYellow, StSideYellow: term = TermYellow;
      StAllRedA, StAllRedB:      term = TermAllRed;
      StSideGreen:               term = TermSide;
      StWalk:                    term = TermWalk;
      default:                   term = TermMain;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StMainGreen: begin
        // Including the current done lets the minimum expire and the request
        // be served on the same edge.
        if ((min_done_q || done) && (side_sensor || pend_q)) state_d = StMainYellow;
      end
      StMainYellow: if (done) state_d = StAllRedA;
      StAllRedA:    if (done) state_d = pend_q ? StWalk : StSideGreen;
      StSideGreen:  if (done) state_d = StSideYellow;
      StSideYellow: if (done) state_d = StAllRedB;
      StWalk:       if (done) state_d = StAllRedB;
      StAllRedB:    if (done) state_d = StMainGreen;
      default:      state_d = StMainGreen;
    endcase
  end

  always_comb begin
    clear      = (state_d != state_q);
    leds_d     = state_leds(state_d);
    min_done_d = (state_q == StMainGreen) && (min_done_q || done);
    pend_d     = pend_q;
    // Entering WALK serves the request and swallows a same-cycle button press.
    if (state_d == StWalk && state_q != StWalk) begin
      pend_d = 1'b0;
    end else if (walk_req && state_q != StWalk) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StMainGreen;
      leds_q     <= LedsMainGreen;
      pend_q     <= 1'b0;
      min_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      leds_q     <= leds_d;
      pend_q     <= pend_d;
      min_done_q <= min_done_d;
    end
  end

  assign leds         = leds_q;
  assign walk_pending = pend_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomised and directed bench for traffic_light_fsm: a cycle-count reference
// model feeds a scoreboard queue that a negedge monitor drains and compares.
module tb_traffic_light_fsm;

  localparam int unsigned DIV    = 4;
  localparam int unsigned TMAIN  = 10;
  localparam int unsigned TYEL   = 3;
  localparam int unsigned TRED   = 1;
  localparam int unsigned TSIDE  = 5;
  localparam int unsigned TWALK  = 4;

  // Model phases, in the order the specification lists them.
  localparam int PMG = 0, PMY = 1, PRA = 2, PSG = 3, PSY = 4, PWK = 5, PRB = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_sensor = 1'b0;
  logic       walk_req = 1'b0;
  logic [6:0] leds;
  logic       walk_pending;

  always #5 clk = ~clk;

  traffic_light_fsm #(
    .TICK_DIV     (DIV),
    .T_MAIN_MIN   (TMAIN),
    .T_YELLOW     (TYEL),
    .T_ALL_RED    (TRED),
    .T_SIDE_GREEN (TSIDE),
    .T_WALK       (TWALK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .side_sensor  (side_sensor),
    .walk_req     (walk_req),
    .leds         (leds),
    .walk_pending (walk_pending)
  );

  int         m_ph;    // current phase
  int         m_el;    // cycles already spent in the phase
  bit         m_pend;
  logic [7:0] exp_q[$];
  int         vectors;
  int         miscompares;

  function automatic int phase_cycles(int p);
    case (p)
      PMY, PSY: return TYEL * DIV;
      PRA, PRB: return TRED * DIV;
      PSG:      return TSIDE * DIV;
      PWK:      return TWALK * DIV;
      default:  return TMAIN * DIV;
    endcase
  endfunction

  function automatic logic [6:0] phase_leds(int p);
    case (p)
      PMG:     return 7'b0011000;
      PMY:     return 7'b0101000;
      PRA:     return 7'b1001000;
      PSG:     return 7'b1000010;
      PSY:     return 7'b1000100;
      PWK:     return 7'b1001001;
      default: return 7'b1001000;
    endcase
  endfunction

  // Advance the model by one clock given this cycle's inputs.
  task automatic model_step(input bit r, input bit s, input bit w);
    int  nxt;
    bit  last;
    if (r) begin
      m_ph = PMG; m_el = 0; m_pend = 1'b0;
      return;
    end
    last = (m_el + 1 == phase_cycles(m_ph));
    nxt  = m_ph;
    case (m_ph)
      PMG: if (m_el + 1 >= int'(TMAIN * DIV) && (s || m_pend)) nxt = PMY;
      PMY: if (last) nxt = PRA;
      PRA: if (last) nxt = m_pend ? PWK : PSG;
      PSG: if (last) nxt = PSY;
      PSY: if (last) nxt = PRB;
      PWK: if (last) nxt = PRB;
      default: if (last) nxt = PMG;
    endcase
    if (nxt == PWK && m_ph != PWK) m_pend = 1'b0;
    else if (w && m_ph != PWK)     m_pend = 1'b1;
    m_el = (nxt != m_ph) ? 0 : m_el + 1;
    m_ph = nxt;
  endtask

  task automatic cycle(input bit r, input bit s, input bit w);
    rst = r; side_sensor = s; walk_req = w;
    model_step(r, s, w);
    exp_q.push_back({phase_leds(m_ph), m_pend});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors += 1;
      if ({leds, walk_pending} !== e) begin
        miscompares += 1;
        $display("FAIL scoreboard t=%0t: leds=%b walk_pending=%b, required leds=%b walk_pending=%b",
                 $time, leds, walk_pending, e[7:1], e[0]);
      end
      vectors += 1;
      if ($countones(leds[6:4]) != 1 || $countones(leds[3:1]) != 1 ||
          (leds[0] && !(leds[6] && leds[3]))) begin
        miscompares += 1;
        $display("FAIL invariant t=%0t: leds=%b is not a legal light combination", $time, leds);
      end
    end
  end

  initial begin
    bit s;
    vectors = 0;
    miscompares = 0;
    m_ph = PMG; m_el = 0; m_pend = 1'b0;

    // Idle: main road rests in green.
    do_reset(2);
    for (int i = 0; i < 200; i++) cycle(1'b0, 1'b0, 1'b0);

    // Side cycle: sensor from cycle 5.
    do_reset(1);
    for (int i = 0; i < 110; i++) cycle(1'b0, i >= 5 && i < 100, 1'b0);

    // Walk priority over a waiting side car; press again during WALK.
    do_reset(1);
    for (int i = 0; i < 180; i++) cycle(1'b0, 1'b1, i == 3 || i == 60);

    // Press exactly on the ALL_RED_A -> WALK edge (last ALL_RED_A cycle is 55).
    do_reset(1);
    for (int i = 0; i < 90; i++) cycle(1'b0, 1'b0, i == 3 || i == 55);

    // Sensor drops before the minimum green has expired.
    do_reset(1);
    for (int i = 0; i < 100; i++) cycle(1'b0, i <= 10, 1'b0);

    // Reset held two cycles in the middle of SIDE_GREEN (56..75).
    do_reset(1);
    for (int i = 0; i < 64; i++) cycle(1'b0, 1'b1, 1'b0);
    do_reset(2);
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1, 1'b0);

    // Random traffic.
    s = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(29) == 0) s = ~s;
      cycle($urandom_range(699) == 0, s, $urandom_range(79) == 0);
    end

    @(negedge clk);
    #1;
    vectors += 1;
    if (exp_q.size() != 0) begin
      miscompares += 1;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
